// File: rtl/seg7_pkg.sv
// Shared types, seven-segment constants and the digit encoder
// for the seg7 value driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_LOAD    = 2'd2
  } state_e;

  localparam logic [7:0] SEG7_BLANK = 8'hFF;
  localparam logic [7:0] SEG7_DASH  = 8'hBF;

  // Active-low, bit0=a .. bit6=g
  localparam logic [6:0] SEG7_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    logic [6:0] code;
    code = SEG7_BLANK[6:0];
    if (nib < 4'd10) code = SEG7_DIGIT[nib];
    return code;
  endfunction

  function automatic int unsigned seg7_max(input int digits);
    int unsigned m;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one input bit per clock.
// busy drops during the final shift so the caller leaves on that edge.
module bin2bcd_serial
  import seg7_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [SR_W-1:0]  sr_q, sr_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[BIN_W+4*i +: 4] >= 4'd5)
        adj[BIN_W+4*i +: 4] = sr_q[BIN_W+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (start_i) begin
      sr_d  = {{(4*DIGITS){1'b0}}, bin_i};
      cnt_d = CNT_W'(BIN_W);
    end else if (cnt_q != '0) begin
      sr_d  = adj << 1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = cnt_q > CNT_W'(1);
  assign bcd_o  = sr_q[SR_W-1 -: 4*DIGITS];

endmodule

// File: rtl/seg7_value_driver.sv
// Binary value to six active-low seven-segment codes via serial BCD.
// Define SEG7_LZ_BLANK_EN to blank leading zero digits.
module seg7_value_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 20
) (
  input  logic              max10_clk1_50,
  input  logic              reset,
  input  logic [BIN_W-1:0]  value,
  input  logic [DIGITS-1:0] dp,
  input  logic              value_valid,
  output logic              value_ready,
  output logic              done,
  output logic [7:0]        hex0,
  output logic [7:0]        hex1,
  output logic [7:0]        hex2,
  output logic [7:0]        hex3,
  output logic [7:0]        hex4,
  output logic [7:0]        hex5
);

  localparam logic [31:0] MAX_VAL = 32'(seg7_max(DIGITS));

  state_e              state_q, state_d;
  logic [DIGITS-1:0]   dp_q;
  logic                ovf_q;
  logic                done_q;
  logic [7:0]          hex_q [DIGITS];
  logic [7:0]          enc   [DIGITS];
  logic                start;
  logic                busy;
  logic [4*DIGITS-1:0] bcd;
`ifdef SEG7_LZ_BLANK_EN
  logic                lz;
`endif

  assign value_ready = (state_q == ST_IDLE) && !reset;
  assign start       = value_valid && value_ready;

  bin2bcd_serial #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk_i   (max10_clk1_50),
    .rst_i   (reset),
    .start_i (start),
    .bin_i   (value),
    .busy_o  (busy),
    .bcd_o   (bcd)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_CONVERT;
      ST_CONVERT: if (!busy) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      enc[i] = {~dp_q[i], seg7_encode(bcd[4*i +: 4])};
      if (ovf_q) enc[i] = {~dp_q[i], SEG7_DASH[6:0]};
    end
`ifdef SEG7_LZ_BLANK_EN
    // Walk down from the top digit; hex0 always shows
    lz = 1'b1;
    for (int i = DIGITS-1; i > 0; i--) begin
      lz = lz && (bcd[4*i +: 4] == 4'd0);
      if (lz && !ovf_q) enc[i] = {~dp_q[i], SEG7_BLANK[6:0]};
    end
`endif
  end

  always_ff @(posedge max10_clk1_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      dp_q    <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) hex_q[i] <= SEG7_BLANK;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_LOAD);
      if (start) begin
        dp_q  <= dp;
        ovf_q <= 32'(value) > MAX_VAL;
      end
      if (state_q == ST_LOAD)
        for (int i = 0; i < DIGITS; i++) hex_q[i] <= enc[i];
    end
  end

  assign done = done_q;
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule

// File: tb/tb_seg7_value_driver.sv
// Directed self-checking bench for seg7_value_driver.
// Honours SEG7_LZ_BLANK_EN for the leading-zero expectations.
module tb_seg7_value_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] value = '0;
  logic [5:0]  dp = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic        done;
  logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [47:0] hex_all;

  int passed = 0;
  int total  = 0;

  always #10 clk = ~clk;

  seg7_value_driver dut (
    .max10_clk1_50 (clk),
    .reset         (reset),
    .value         (value),
    .dp            (dp),
    .value_valid   (value_valid),
    .value_ready   (value_ready),
    .done          (done),
    .hex0          (hex0),
    .hex1          (hex1),
    .hex2          (hex2),
    .hex3          (hex3),
    .hex4          (hex4),
    .hex5          (hex5)
  );

  assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

  // Offer one value, return edges from accept to done (accept edge = 1)
  task automatic conv(input logic [19:0] v, input logic [5:0] d,
                      output int lat, output bit rdy_ok);
    int n;
    rdy_ok = 1'b1;
    lat = -1;
    @(negedge clk);
    value = v;
    dp = d;
    value_valid = 1'b1;
    @(posedge clk);
    #1;
    value_valid = 1'b0;
    value = '0;
    dp = '0;
    n = 1;
    while (n < 40 && !done) begin
      if (value_ready) rdy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    if (done) lat = n;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (hex_all !== 48'hFFFFFFFFFFFF || done !== 1'b0 || value_ready !== 1'b0)
        $display("FAIL reset_state: hex=%h done=%b ready=%b expected FF.. 0 0",
                 hex_all, done, value_ready);
      else passed++;
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (value_ready !== 1'b1)
      $display("FAIL ready_after_reset: got %b expected 1", value_ready);
    else passed++;
  endtask

  task automatic test_value_123456;
    int lat;
    bit rok;
    conv(20'd123456, 6'b0, lat, rok);
    total++;
    if (lat !== 22) $display("FAIL lat_123456: got %0d expected 22", lat);
    else passed++;
    total++;
    if (hex_all !== 48'hF9A4B0999282)
      $display("FAIL hex_123456: got %h expected F9A4B0999282", hex_all);
    else passed++;
    total++;
    if (!rok) $display("FAIL ready_low_123456: got ready=1 expected 0 during convert");
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) $display("FAIL done_pulse_width: got %b expected 0", done);
    else passed++;
  endtask

  task automatic test_zero_and_max;
    int lat;
    bit rok;
    logic [47:0] exp0;
`ifdef SEG7_LZ_BLANK_EN
    exp0 = 48'hFFFFFFFFFFC0;
`else
    exp0 = 48'hC0C0C0C0C0C0;
`endif
    conv(20'd0, 6'b0, lat, rok);
    total++;
    if (hex_all !== exp0 || lat !== 22)
      $display("FAIL zero: got %h lat %0d expected %h lat 22", hex_all, lat, exp0);
    else passed++;
    conv(20'd999999, 6'b0, lat, rok);
    total++;
    if (hex_all !== 48'h909090909090 || lat !== 22)
      $display("FAIL max_999999: got %h lat %0d expected 909090909090 lat 22",
               hex_all, lat);
    else passed++;
  endtask

  task automatic test_dp;
    int lat;
    bit rok;
    logic [47:0] exp5;
`ifdef SEG7_LZ_BLANK_EN
    exp5 = 48'h7FFFFFFF7F92;
`else
    exp5 = 48'h40C0C0C04092;
`endif
    conv(20'd5, 6'b100010, lat, rok);
    total++;
    if (hex_all !== exp5)
      $display("FAIL dp_5: got %h expected %h", hex_all, exp5);
    else passed++;
  endtask

  task automatic test_overflow;
    int lat;
    bit rok;
    conv(20'd1000000, 6'b000001, lat, rok);
    total++;
    if (hex_all !== 48'hBFBFBFBFBF3F || lat !== 22)
      $display("FAIL overflow: got %h lat %0d expected BFBFBFBFBF3F lat 22",
               hex_all, lat);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int n;
    bit ok;
    @(negedge clk);
    value = 20'd111111;
    dp = 6'b0;
    value_valid = 1'b1;
    @(posedge clk);
    #1;
    n = 1;
    ok = 1'b1;
    while (n < 40 && !done) begin
      if (value_ready) ok = 1'b0;
      @(negedge clk);
      value = 20'(300000 + n);
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (hex_all !== 48'hF9F9F9F9F9F9 || n !== 22 || !ok)
      $display("FAIL b2b_first: got %h n %0d ok %b expected F9F9F9F9F9F9 n 22",
               hex_all, n, ok);
    else passed++;
    @(negedge clk);
    value = 20'd654321;
    @(posedge clk);
    #1;
    value_valid = 1'b0;
    value = '0;
    total++;
    if (value_ready !== 1'b0)
      $display("FAIL b2b_accept_on_done: ready got %b expected 0", value_ready);
    else passed++;
    n = 1;
    while (n < 40 && !done) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (hex_all !== 48'h829299B0A4F9 || n !== 22)
      $display("FAIL b2b_second: got %h n %0d expected 829299B0A4F9 n 22",
               hex_all, n);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int n;
    int lat;
    bit rok;
    bit no_done;
    logic [47:0] exp42;
`ifdef SEG7_LZ_BLANK_EN
    exp42 = 48'hFFFFFFFF99A4;
`else
    exp42 = 48'hC0C0C0C099A4;
`endif
    @(negedge clk);
    value = 20'd777777;
    value_valid = 1'b1;
    @(posedge clk);
    #1;
    value_valid = 1'b0;
    n = 1;
    while (n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (hex_all !== 48'hFFFFFFFFFFFF || done !== 1'b0 || value_ready !== 1'b0)
      $display("FAIL mid_reset: hex=%h done=%b ready=%b expected FF.. 0 0",
               hex_all, done, value_ready);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (value_ready !== 1'b1)
      $display("FAIL ready_after_mid_reset: got %b expected 1", value_ready);
    else passed++;
    no_done = 1'b1;
    repeat (30) begin
      if (done !== 1'b0) no_done = 1'b0;
      @(posedge clk);
      #1;
    end
    total++;
    if (!no_done) $display("FAIL aborted_done: got done=1 expected none");
    else passed++;
    conv(20'd42, 6'b0, lat, rok);
    total++;
    if (hex_all !== exp42 || lat !== 22 || !rok)
      $display("FAIL after_reset_42: got %h lat %0d expected %h lat 22",
               hex_all, lat, exp42);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_value_123456();
    test_zero_and_max();
    test_dp();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
